// File: rtl/rr_arb_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb_mux: N-way round-robin arbitrated mux, single registered output.  |
// | Optional packet lock when RRMUX_LOCK_EN is defined.      Revision: 1.0   |
// +--------------------------------------------------------------------------+
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [N*WIDTH-1:0]   in_data_i,
    input  logic [N-1:0]         in_valid_i,
`ifdef RRMUX_LOCK_EN
    input  logic [N-1:0]         in_last_i,
    output logic                 out_last_o,
`endif
    output logic [N-1:0]         in_ready_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [SELW-1:0]      out_sel_o
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [N-1:0]     elig;
    logic             found;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  ptr_inc;
    logic             load;
    logic             accept;

`ifdef RRMUX_LOCK_EN
    logic             lock_q,     lock_d;
    logic [SELW-1:0]  lock_ch_q,  lock_ch_d;
    logic             out_last_q, out_last_d;
`endif

    assign load   = ~out_valid_q | out_ready_i;
    assign accept = load & found;

    always_comb begin
        elig = in_valid_i;
`ifdef RRMUX_LOCK_EN
        if (lock_q) begin
            for (int i = 0; i < N; i++) begin
                elig[i] = in_valid_i[i] & (lock_ch_q == SELW'(i));
            end
        end
`endif
    end

    // Lowest eligible index at or above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        found = |elig;
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                grant = SELW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i] && (SELW'(i) >= ptr_q)) begin
                grant = SELW'(i);
            end
        end
    end

    assign ptr_inc = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

    always_comb begin
        in_ready_o = '0;
        if (accept && !reset_i) begin
            in_ready_o[grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RRMUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            out_valid_d = found;
        end
        if (accept) begin
            out_data_d = in_data_i[int'(grant) * WIDTH +: WIDTH];
            out_sel_d  = grant;
`ifdef RRMUX_LOCK_EN
            out_last_d = in_last_i[grant];
            if (in_last_i[grant]) begin
                lock_d = 1'b0;
                ptr_d  = ptr_inc;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant;
            end
`else
            ptr_d = ptr_inc;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef RRMUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef RRMUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;
`ifdef RRMUX_LOCK_EN
    assign out_last_o  = out_last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_arb_mux: directed scoreboard bench for rr_arb_mux (N=4 and N=3).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;

    logic [23:0] d3_data;
    logic [2:0]  d3_valid;
    logic [2:0]  d3_ready;
    logic [7:0]  d3_odata;
    logic        d3_ovalid;
    logic        d3_oready;
    logic [1:0]  d3_sel;

`ifdef RRMUX_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
    logic [2:0]  d3_last;
    logic        d3_olast;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(8), .N(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
`ifdef RRMUX_LOCK_EN
        .in_last_i   (in_last),
        .out_last_o  (out_last),
`endif
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sel_o   (out_sel)
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) dut3 (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_data_i   (d3_data),
        .in_valid_i  (d3_valid),
`ifdef RRMUX_LOCK_EN
        .in_last_i   (d3_last),
        .out_last_o  (d3_olast),
`endif
        .in_ready_o  (d3_ready),
        .out_data_o  (d3_odata),
        .out_valid_o (d3_ovalid),
        .out_ready_i (d3_oready),
        .out_sel_o   (d3_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] s, input logic l);
        exp_t e;
        e.d = d;
        e.s = s;
        e.l = l;
        sb.push_back(e);
    endtask

    // One cycle: check in_ready mid-cycle, then score any beat accepted at the edge.
    task automatic tick(input logic [3:0] exp_rdy);
        logic acc;
        exp_t e;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = |(in_valid & in_ready);
        @(posedge clk);
        #1;
        if (acc) begin
            chk("sb_pending", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_sel", 32'(out_sel), 32'(e.s));
`ifdef RRMUX_LOCK_EN
                chk("out_last", 32'(out_last), 32'(e.l));
`endif
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_data   = 32'h44332211;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        d3_data   = 24'h3C2B1A;
        d3_valid  = 3'b000;
        d3_oready = 1'b1;
`ifdef RRMUX_LOCK_EN
        in_last   = 4'hF;
        d3_last   = 3'b111;
`endif
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        reset = 1'b0;

        // Round-robin, all channels valid
        push(8'h11, 2'd0, 1'b1); tick(4'b0001);
        push(8'h22, 2'd1, 1'b1); tick(4'b0010);
        push(8'h33, 2'd2, 1'b1); tick(4'b0100);
        push(8'h44, 2'd3, 1'b1); tick(4'b1000);
        push(8'h11, 2'd0, 1'b1); tick(4'b0001);

        // Sparse valid with wrap: grant 2 leaves ptr=3
        in_valid = 4'b0100;
        push(8'h33, 2'd2, 1'b1); tick(4'b0100);
        in_valid = 4'b1010;
        push(8'h44, 2'd3, 1'b1); tick(4'b1000);
        push(8'h22, 2'd1, 1'b1); tick(4'b0010);

        // Backpressure holding A5
        in_data  = 32'h44A52211;
        in_valid = 4'b0100;
        push(8'hA5, 2'd2, 1'b1); tick(4'b0100);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int c = 0; c < 3; c++) begin
            tick(4'b0000);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'hA5);
        end
        out_ready = 1'b1;
        push(8'h44, 2'd3, 1'b1); tick(4'b1000);
        chk("sb_drained_bp", 32'(sb.size()), 32'd0);

        // Idle drain of a single beat
        in_data  = 32'h445A2211;
        in_valid = 4'b0100;
        push(8'h5A, 2'd2, 1'b1); tick(4'b0100);
        in_valid = 4'b0000;
        tick(4'b0000);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data_hold", 32'(out_data), 32'h5A);
        chk("idle_sel_hold", 32'(out_sel), 32'd2);
        tick(4'b0000);
        chk("idle_valid2", 32'(out_valid), 32'd0);

        // Reset while stalled
        in_data  = 32'h44332211;
        in_valid = 4'hF;
        push(8'h44, 2'd3, 1'b1); tick(4'b1000);
        out_ready = 1'b0;
        tick(4'b0000);
        chk("pre_rst_data", 32'(out_data), 32'h44);
        reset = 1'b1;
        #2;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_data", 32'(out_data), 32'd0);
        chk("async_sel", 32'(out_sel), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        push(8'h11, 2'd0, 1'b1); tick(4'b0001);

`ifdef RRMUX_LOCK_EN
        // Channel 1 sends a 3-beat packet while channel 0 stays valid
        in_valid = 4'b0011;
        in_last  = 4'b1101;
        push(8'h22, 2'd1, 1'b0); tick(4'b0010);
        push(8'h22, 2'd1, 1'b0); tick(4'b0010);
        in_last  = 4'b1111;
        push(8'h22, 2'd1, 1'b1); tick(4'b0010);
        push(8'h11, 2'd0, 1'b1); tick(4'b0001);
`endif
        in_valid = 4'b0000;
        tick(4'b0000);
        chk("sb_drained_end", 32'(sb.size()), 32'd0);

        // N=3: grant to channel 2 must wrap ptr to 0
        d3_valid = 3'b100;
        @(negedge clk);
        chk("n3_ready_a", 32'(d3_ready), 32'b100);
        @(posedge clk); #1;
        chk("n3_data_a", 32'(d3_odata), 32'h3C);
        chk("n3_sel_a", 32'(d3_sel), 32'd2);
        d3_valid = 3'b111;
        @(negedge clk);
        chk("n3_ready_b", 32'(d3_ready), 32'b001);
        @(posedge clk); #1;
        chk("n3_data_b", 32'(d3_odata), 32'h1A);
        chk("n3_sel_b", 32'(d3_sel), 32'd0);
        @(negedge clk);
        chk("n3_ready_c", 32'(d3_ready), 32'b010);
        @(posedge clk); #1;
        chk("n3_data_c", 32'(d3_odata), 32'h2B);
        d3_valid = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
